// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory system RAM blocks.
package hack_mem_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_clear_if.sv
// User-side bus of ram_clear: write data, load, address, read data and busy.
interface ram_clear_if
  import hack_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned ADDR_W = 14
);

  logic [WIDTH-1:0]  data_in;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [WIDTH-1:0]  data_out;
  logic              busy;

  modport master (
    output data_in,
    output load,
    output address,
    input  data_out,
    input  busy
  );

  modport slave (
    input  data_in,
    input  load,
    input  address,
    output data_out,
    output busy
  );

endinterface

// File: rtl/ram_clear_seq.sv
// Self-clear sequencer: walks clr_ptr over every word after reset, then hands the RAM to the user.
module ram_clear_seq
  import hack_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              reset_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_o     = 1'b0;
    clr_we_o   = 1'b0;
    clr_addr_o = ptr_q;
    case (state_q)
      CLEAR: begin
        busy_o   = 1'b1;
        clr_we_o = 1'b1;
        // Pointer parks on the last word rather than wrapping.
        if (ptr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

// File: rtl/ram_clear.sv
// Parametrised RAM that zeroes itself after every reset. Define READ_REG_EN for a registered
// (1-cycle, write-first) read port; otherwise the read is combinational.
module ram_clear
  import hack_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = WORD_W,
  parameter int unsigned ADDR_W = 14
) (
  input  logic        clk_i,
  input  logic        reset_i,
  ram_clear_if.slave  bus
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [WIDTH-1:0]  mem_q [DEPTH];

  logic              busy_w;
  logic              clr_we_w;
  logic [ADDR_W-1:0] clr_addr_w;

  logic              we_w;
  logic [ADDR_W-1:0] waddr_w;
  logic [WIDTH-1:0]  wdata_w;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .busy_o     (busy_w),
    .clr_we_o   (clr_we_w),
    .clr_addr_o (clr_addr_w)
  );

  // The sequencer owns the write port while busy; user load is dropped.
  always_comb begin
    we_w    = bus.load;
    waddr_w = bus.address;
    wdata_w = bus.data_in;
    if (busy_w) begin
      we_w    = clr_we_w;
      waddr_w = clr_addr_w;
      wdata_w = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_w) begin
      mem_q[waddr_w] <= wdata_w;
    end
  end

`ifdef READ_REG_EN
  logic [WIDTH-1:0] out_q, out_d;

  // In IDLE the write address equals the read address, so forwarding gives write-first.
  always_comb begin
    out_d = '0;
    if (!busy_w) begin
      out_d = we_w ? wdata_w : mem_q[bus.address];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.data_out = out_q;
`else
  always_comb begin
    bus.data_out = busy_w ? '0 : mem_q[bus.address];
  end
`endif

  assign bus.busy = busy_w;

endmodule
